midi_note_receiver: RTL and testbench



---
 rtl/midi_pkg.sv | 10 +
 rtl/midi_uart_rx.sv | 93 +++++++++
 rtl/midi_note_receiver.sv | 100 ++++++++++
 tb/tb_midi_note_receiver.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared constants and state encodings for the MIDI note receiver.
package midi_pkg;
   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [7:0] SYS_MIN  = 8'hF0;
   localparam logic [7:0] RT_MIN   = 8'hF8;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uartState_t;
   typedef enum logic [1:0] {P_IDLE, P_DATA1, P_DATA2} parseState_t;
endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 UART receiver for the MIDI line: synchroniser, mid-bit sampling, framing checks.
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = 800
) (
   input  logic       pixelClk,
   input  logic       reset,
   input  logic       midiRx,
   output logic [7:0] rxByte,
   output logic       byteValid,
   output logic       framingError,
   output logic [7:0] errCount
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic             rxMeta, rxSync, rxPrev;
   uartState_t       state, stateNext;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bitIdx;
   logic [7:0]       shiftReg;
   logic             bitTick, halfTick, cntClr;

   assign bitTick  = (cnt == BIT_LAST);
   assign halfTick = (cnt == HALF_LAST);
   assign rxByte   = shiftReg;

   always_comb begin
      stateNext = state;
      cntClr    = 1'b0;
      case (state)
         IDLE: begin
            cntClr = 1'b1;
            if (rxPrev && !rxSync) stateNext = START;
         end
         // a start bit that is high again at mid-bit is a glitch
         START: if (halfTick) begin
            cntClr    = 1'b1;
            stateNext = rxSync ? IDLE : DATA;
         end
         DATA: if (bitTick) begin
            cntClr = 1'b1;
            if (bitIdx == 3'd7) stateNext = STOP;
         end
         STOP: if (bitTick) begin
            cntClr    = 1'b1;
            stateNext = rxSync ? IDLE : WAIT_HIGH;
         end
         WAIT_HIGH: begin
            cntClr = 1'b1;
            if (rxSync) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge pixelClk) begin
      if (reset) begin
         // synchroniser clears low so reset itself can never fake a start edge
         rxMeta       <= 1'b0;
         rxSync       <= 1'b0;
         rxPrev       <= 1'b0;
         state        <= IDLE;
         cnt          <= '0;
         bitIdx       <= '0;
         shiftReg     <= '0;
         byteValid    <= 1'b0;
         framingError <= 1'b0;
         errCount     <= '0;
      end else begin
         rxMeta       <= midiRx;
         rxSync       <= rxMeta;
         rxPrev       <= rxSync;
         state        <= stateNext;
         cnt          <= cntClr ? '0 : cnt + 1'b1;
         byteValid    <= 1'b0;
         framingError <= 1'b0;
         if (state == DATA && bitTick) begin
            shiftReg <= {rxSync, shiftReg[7:1]};
            bitIdx   <= bitIdx + 1'b1;
         end
         if (state == STOP && bitTick) begin
            if (rxSync) byteValid <= 1'b1;
            else begin
               framingError <= 1'b1;
               if (errCount != 8'hFF) errCount <= errCount + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/midi_note_receiver.sv
// MIDI front end: UART plus Note-On/Off parser holding {note, velocity} of the sounding key.
module midi_note_receiver
   import midi_pkg::*;
#(
   parameter int         CLK_FREQ = 25000000,
   parameter int         BAUD     = 31250,
   parameter logic [3:0] CHANNEL  = 4'd0,
   parameter logic       OMNI     = 1'b1
) (
   input  logic        pixelClk,
   input  logic        reset,
   input  logic        midiRx,
   output logic [15:0] midiNoteOut,
   output logic        noteValid,
   output logic        byteValid,
   output logic        framingError,
   output logic [7:0]  errCount
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

   logic [7:0]  rxByte;
   parseState_t pState, pNext;
   logic        runValid, runValidNext, runOn, runOnNext;
   logic [7:0]  noteReg, noteNext;
   logic [15:0] noteOutNext;
   logic        isNoteStatus, chanOk;

   midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uUart (
      .pixelClk    (pixelClk),
      .reset       (reset),
      .midiRx      (midiRx),
      .rxByte      (rxByte),
      .byteValid   (byteValid),
      .framingError(framingError),
      .errCount    (errCount)
   );

   assign isNoteStatus = (rxByte[7:4] == NOTE_ON) || (rxByte[7:4] == NOTE_OFF);
   assign chanOk       = OMNI || (rxByte[3:0] == CHANNEL);

   always_comb begin
      pNext        = pState;
      runValidNext = runValid;
      runOnNext    = runOn;
      noteNext     = noteReg;
      noteOutNext  = midiNoteOut;
      if (byteValid) begin
         if (rxByte >= RT_MIN) begin
            // realtime bytes are transparent to the parser
         end else if (rxByte >= SYS_MIN) begin
            runValidNext = 1'b0;
            pNext        = P_IDLE;
         end else if (rxByte[7]) begin
            if (isNoteStatus && chanOk) begin
               runValidNext = 1'b1;
               runOnNext    = (rxByte[7:4] == NOTE_ON);
               pNext        = P_DATA1;
            end else begin
               runValidNext = 1'b0;
               pNext        = P_IDLE;
            end
         end else begin
            case (pState)
               P_IDLE: if (runValid) begin
                  noteNext = rxByte;
                  pNext    = P_DATA2;
               end
               P_DATA1: begin
                  noteNext = rxByte;
                  pNext    = P_DATA2;
               end
               P_DATA2: begin
                  pNext = P_IDLE;
                  if (runOn && rxByte != 8'd0) noteOutNext = {noteReg, rxByte};
                  else if (noteReg == midiNoteOut[15:8]) noteOutNext = 16'd0;
               end
               default: pNext = P_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge pixelClk) begin
      if (reset) begin
         pState      <= P_IDLE;
         runValid    <= 1'b0;
         runOn       <= 1'b0;
         noteReg     <= '0;
         midiNoteOut <= '0;
         noteValid   <= 1'b0;
      end else begin
         pState      <= pNext;
         runValid    <= runValidNext;
         runOn       <= runOnNext;
         noteReg     <= noteNext;
         midiNoteOut <= noteOutNext;
         noteValid   <= (noteOutNext != midiNoteOut);
      end
   end
endmodule

// File: tb/tb_midi_note_receiver.sv
// Directed bench: serialises MIDI bytes at 100 clocks/bit into an omni and a channel-1 receiver.
module tb_midi_note_receiver;
   localparam int CPB = 100;

   logic        pixelClk = 1'b0;
   logic        reset    = 1'b1;
   logic        midiRx   = 1'b1;
   logic [15:0] noteOut, noteOutCh;
   logic        nv, bv, fe, nvCh, bvCh, feCh;
   logic [7:0]  ec, ecCh;

   int testsRun = 0, failCnt = 0;
   int cyc = 0, nvCnt = 0, bvCnt = 0, feCnt = 0, nvChCnt = 0;
   int lastBvCyc = 0, lastNvCyc = 0;
   int nv0, bv0, fe0, nvCh0;

   midi_note_receiver #(.CLK_FREQ(3125000)) dut (
      .pixelClk(pixelClk), .reset(reset), .midiRx(midiRx),
      .midiNoteOut(noteOut), .noteValid(nv), .byteValid(bv),
      .framingError(fe), .errCount(ec)
   );

   midi_note_receiver #(.CLK_FREQ(3125000), .CHANNEL(4'd1), .OMNI(1'b0)) dutCh (
      .pixelClk(pixelClk), .reset(reset), .midiRx(midiRx),
      .midiNoteOut(noteOutCh), .noteValid(nvCh), .byteValid(bvCh),
      .framingError(feCh), .errCount(ecCh)
   );

   always #5 pixelClk = ~pixelClk;

   always @(negedge pixelClk) begin
      cyc <= cyc + 1;
      if (bv) begin bvCnt <= bvCnt + 1; lastBvCyc <= cyc; end
      if (nv) begin nvCnt <= nvCnt + 1; lastNvCyc <= cyc; end
      if (fe) feCnt <= feCnt + 1;
      if (nvCh) nvChCnt <= nvChCnt + 1;
   end

   task automatic tick(int n);
      repeat (n) begin @(posedge pixelClk); #1; end
   endtask

   task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mark();
      nv0 = nvCnt; bv0 = bvCnt; fe0 = feCnt; nvCh0 = nvChCnt;
   endtask

   // leaves the line at the stop-bit level so a bad stop can be stretched
   task automatic sendFrame(logic [7:0] b, logic stopBit);
      midiRx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         midiRx = b[i];
         tick(CPB);
      end
      midiRx = stopBit;
      tick(CPB);
   endtask

   task automatic sendByte(logic [7:0] b);
      sendFrame(b, 1'b1);
   endtask

   initial begin
      tick(3);
      check("rst_note", noteOut, 16'h0000);
      check("rst_pulses", {13'd0, nv, bv, fe}, 16'h0000);
      check("rst_errcnt", {8'd0, ec}, 16'h0000);
      reset = 1'b0;
      tick(2 * CPB);

      mark();
      sendByte(8'h90); sendByte(8'h3C); sendByte(8'h40);
      check("noteon_value", noteOut, 16'h3C40);
      check("noteon_nv", 16'(nvCnt - nv0), 16'd1);
      check("noteon_bv", 16'(bvCnt - bv0), 16'd3);
      check("noteon_latency", 16'(lastNvCyc - lastBvCyc), 16'd1);

      mark();
      sendByte(8'h3E); sendByte(8'h50);
      check("running_value", noteOut, 16'h3E50);
      check("running_nv", 16'(nvCnt - nv0), 16'd1);

      mark();
      sendByte(8'h80); sendByte(8'h3C); sendByte(8'h00);
      check("off_nomatch_value", noteOut, 16'h3E50);
      check("off_nomatch_nv", 16'(nvCnt - nv0), 16'd0);

      mark();
      sendByte(8'h90); sendByte(8'h3E); sendByte(8'hF8); sendByte(8'h00);
      check("rt_vel0_value", noteOut, 16'h0000);
      check("rt_vel0_nv", 16'(nvCnt - nv0), 16'd1);
      check("rt_vel0_bv", 16'(bvCnt - bv0), 16'd4);

      mark();
      sendFrame(8'h55, 1'b0);
      tick(3 * CPB);
      midiRx = 1'b1;
      tick(CPB);
      check("frame_fe", 16'(feCnt - fe0), 16'd1);
      check("frame_errcnt", {8'd0, ec}, 16'd1);
      check("frame_errcnt_ch", {8'd0, ecCh}, 16'd1);
      check("frame_bv", 16'(bvCnt - bv0), 16'd0);
      mark();
      sendByte(8'h90); sendByte(8'h24); sendByte(8'h7F);
      check("after_frame_value", noteOut, 16'h247F);
      check("after_frame_nv", 16'(nvCnt - nv0), 16'd1);

      mark();
      midiRx = 1'b0;
      tick(20);
      midiRx = 1'b1;
      tick(3 * CPB);
      check("glitch_bv", 16'(bvCnt - bv0), 16'd0);
      check("glitch_fe", 16'(feCnt - fe0), 16'd0);
      check("glitch_value", noteOut, 16'h247F);

      mark();
      sendByte(8'h90); sendByte(8'h30); sendByte(8'h40);
      check("omni_value", noteOut, 16'h3040);
      check("ch1_reject_value", noteOutCh, 16'h0000);
      check("ch1_reject_nv", 16'(nvChCnt - nvCh0), 16'd0);

      mark();
      sendByte(8'h91); sendByte(8'h30); sendByte(8'h40);
      check("ch1_accept_value", noteOutCh, 16'h3040);
      check("ch1_accept_nv", 16'(nvChCnt - nvCh0), 16'd1);
      check("same_noteon_value", noteOut, 16'h3040);
      check("same_noteon_nv", 16'(nvCnt - nv0), 16'd0);

      sendByte(8'h90); sendByte(8'h3C);
      midiRx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) tick(CPB);
      reset = 1'b1;
      tick(1);
      check("midrst_note", noteOut, 16'h0000);
      check("midrst_note_ch", noteOutCh, 16'h0000);
      check("midrst_pulses", {13'd0, nv, bv, fe}, 16'h0000);
      check("midrst_errcnt", {8'd0, ec}, 16'h0000);
      reset  = 1'b0;
      midiRx = 1'b1;
      tick(3 * CPB);
      mark();
      sendByte(8'h40); sendByte(8'h50);
      check("lone_data_value", noteOut, 16'h0000);
      check("lone_data_nv", 16'(nvCnt - nv0), 16'd0);
      check("lone_data_bv", 16'(bvCnt - bv0), 16'd2);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
      $finish;
   end
endmodule
